// File: rtl/fetch_pc_if.sv
`default_nettype none
// ============================================================================
// fetch_pc_if : instruction-memory request bus and fetch-to-decode handshake
// Revision    : 1.0
// ============================================================================
interface fetch_pc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc,
    input  imem_rdata, imem_rvalid, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc,
    output imem_rdata, imem_rvalid, if_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// fetch_pc : PC owner and one-outstanding instruction fetch with branch redirect
// Revision : 1.0
// ============================================================================
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  fetch_pc_if.master  bus,
  output logic        flush,
  output logic        err_misalign
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_redir_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic        r_flush;
  logic        r_err;
  logic        w_redirect;
  logic        w_aligned;

  assign w_redirect = br_valid & br_taken;
  assign w_aligned  = (br_target[1:0] == 2'b00);

  // A redirect only skips draining when no response is still owed to us.
  always_comb begin
    w_redir_state = ST_DRAIN;
    if ((r_state == ST_HOLD) || ((r_state == ST_WAIT) && bus.imem_rvalid))
      w_redir_state = ST_REQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RST;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_inst  <= 32'd0;
      r_if_pc    <= 32'd0;
      r_flush    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_RST: r_state <= ST_REQ;
        ST_REQ, ST_WAIT, ST_HOLD: begin
          if (w_redirect) begin
            r_flush    <= 1'b1;
            r_if_valid <= 1'b0;
            if (w_aligned) begin
              r_pc    <= br_target;
              r_state <= w_redir_state;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_HALT;
            end
          end else if (r_state == ST_REQ) begin
            r_state <= ST_WAIT;
          end else if (r_state == ST_WAIT) begin
            if (bus.imem_rvalid) begin
              r_if_inst  <= bus.imem_rdata;
              r_if_pc    <= r_pc;
              r_if_valid <= 1'b1;
              r_state    <= ST_HOLD;
            end
          end else if (r_if_valid && bus.if_ready) begin
            r_if_valid <= 1'b0;
            r_pc       <= r_pc + 32'd4;
            r_state    <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_rvalid)
            r_state <= ST_REQ;
        end
        ST_HALT: r_if_valid <= 1'b0;
        default: r_state <= ST_RST;
      endcase
    end
  end

  assign bus.imem_req  = (r_state == ST_REQ);
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_inst   = r_if_inst;
  assign bus.if_pc     = r_if_pc;
  assign flush         = r_flush;
  assign err_misalign  = r_err;

endmodule
`default_nettype wire

// File: doc/fetch_pc.md
# fetch_pc

Program-counter and instruction-fetch stage of the multicycle core. It owns the PC and issues one-outstanding requests to instruction memory. It presents each fetched instruction to decode over a valid/ready handshake. It consumes the taken/not-taken decision produced by the branch comparison stage, together with the ALU-computed target, and redirects fetch, flushing in-flight work.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address fetched first after reset.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- br_valid  input  1  instruction in EX is a branch/jump; br_taken/br_target are meaningful this cycle.
- br_taken  input  1  comparison result from the branch stage (1 = redirect).
- br_target  input  32  redirect address from ALU.
- imem_req  output  1  request strobe, exactly one cycle per request.
- imem_addr  output  32  request address (= current PC).
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- imem_rvalid  input  1  response strobe; in order, ≥1 cycle after imem_req.
- if_valid  output  1  if_inst/if_pc hold a fetched instruction for decode.
- if_ready  input  1  decode accepts when if_valid & if_ready.
- if_inst  output  32  fetched instruction.
- if_pc  output  32  address of if_inst.
- flush  output  1  one-cycle pulse: younger pipeline contents invalid.
- err_misalign  output  1  sticky: taken redirect to target with [1:0] ≠ 0.

## Operation
- Reset values: pc = RESET_PC, state = RST, imem_req = 0, if_valid = 0, if_inst = 0, if_pc = 0, flush = 0, err_misalign = 0.
- imem_req = (state == REQ); imem_addr = pc at all times.
- States and transitions:
  - RST: → REQ on first clock after rst_n release.
  - REQ: request issued this cycle; → WAIT.
  - WAIT: on imem_rvalid, capture if_inst <= imem_rdata, if_pc <= pc, if_valid <= 1; → HOLD.
  - HOLD: on if_valid & if_ready, if_valid <= 0, pc <= pc + 4 (mod 2^32, wraps FFFF_FFFC → 0); → REQ.
  - DRAIN: wait for the orphaned response; on imem_rvalid discard data; → REQ.
  - HALT: imem_req = 0, if_valid = 0; exits only via reset.
- Redirect = br_valid & br_taken, checked in REQ, WAIT, HOLD (ignored in RST, DRAIN, HALT). br_valid & !br_taken has no effect.
  - Aligned target: pc <= br_target, if_valid <= 0, flush <= 1 for the next cycle only.
  - REQ → DRAIN: request already issued.
  - WAIT without rvalid → DRAIN.
  - WAIT with simultaneous rvalid: data discarded; → REQ.
  - HOLD → REQ. Redirect wins over a simultaneous if_ready handshake; pc is not incremented.
  - Misaligned target: err_misalign <= 1, if_valid <= 0, flush <= 1 one cycle, pc unchanged; → HALT.
- if_inst/if_pc are stable while if_valid & !if_ready.

## Timing
- All outputs registered or Moore-decoded from state; no input-to-output combinational path.
- Best-case fetch with 1-cycle memory:
  - REQ at cycle n, rvalid at n+1, if_valid at n+2.
  - Accepted at n+2 gives next REQ at n+3, so one instruction per 3 cycles.
- Redirect latency: new address on imem_req at:
  - cycle +1 after redirect from HOLD or WAIT-with-rvalid;
  - cycle +1 after the drained rvalid otherwise.
- Asynchronous reset mid-request: all state cleared immediately. A memory response arriving after reset release while in RST or REQ is ignored; the memory side is reset on the same rst_n.

## Test plan
- Reset, RESET_PC=32'h100, memory latency 1, if_ready=1: imem_addr sequence 100, 104, 108. if_pc matches, if_valid pulses every 3rd cycle, flush never asserted.
- Backpressure: if_ready=0 for 5 cycles in HOLD: if_inst/if_pc constant and no imem_req. Releasing if_ready gives next request at pc+4.
- Redirect in WAIT, latency 3, br_target=32'h40: flush pulses one cycle, DRAIN swallows the old response (if_valid stays 0), next imem_addr=40.
- Redirect coincident with imem_rvalid and, separately, with the if_ready handshake in HOLD: response/instruction dropped, next imem_addr=br_target, no pc+4 step.
- Taken redirect to 32'h42: err_misalign=1 sticky, imem_req=0 forever, reset clears it and fetch restarts at RESET_PC.
- rst_n asserted mid-WAIT: outputs return to reset values asynchronously. After release, first imem_addr=RESET_PC; br_valid & !br_taken during run causes no change.
